// File: rtl/add_pipe_sched.sv
// add_pipe_sched: round-robin front end for one shared fixed-latency adder.
// Tags each issue with its requester ID and returns sums in order via a FIFO.
module add_pipe_sched #(
  parameter  int P_NUM_REQ    = 4,
  parameter  int P_DATA_SIZE  = 16,
  parameter  int P_LATENCY    = 3,
  parameter  int P_FIFO_DEPTH = 8,
  localparam int C_ID_W =
    (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [P_NUM_REQ-1:0]   i_req_vld,
  output logic [P_NUM_REQ-1:0]   o_req_rdy,
  input  logic [P_NUM_REQ*P_DATA_SIZE-1:0] i_req_a,
  input  logic [P_NUM_REQ*P_DATA_SIZE-1:0] i_req_b,
  input  logic [P_NUM_REQ-1:0]   i_req_c,
  output logic                   o_add_vld,
  output logic [P_DATA_SIZE-1:0] o_add_a,
  output logic [P_DATA_SIZE-1:0] o_add_b,
  output logic                   o_add_c,
  input  logic                   i_add_vld,
  input  logic [P_DATA_SIZE:0]   i_add_s,
  output logic                   o_res_vld,
  input  logic                   i_res_rdy,
  output logic [P_DATA_SIZE:0]   o_res_s,
  output logic [C_ID_W-1:0]      o_res_id,
  output logic                   o_busy,
  output logic                   o_err
);

  localparam int C_S_W   = P_DATA_SIZE + 1;
  localparam int C_CNT_W = $clog2(P_FIFO_DEPTH + 1);
  localparam int C_PTR_W = $clog2(P_FIFO_DEPTH);
  localparam int C_PW1   = C_PTR_W + 1;
  localparam int C_SUP_W = $clog2(P_LATENCY + 1);
  localparam int C_ENT_W = C_ID_W + C_S_W;

  localparam logic [C_CNT_W-1:0] C_CNT_MAX =
    C_CNT_W'(P_FIFO_DEPTH);
  localparam logic [C_SUP_W-1:0] C_SUP_INIT =
    C_SUP_W'(P_LATENCY);

  // arbitration
  logic [C_ID_W-1:0]    ptr_q;
  logic [C_ID_W-1:0]    ptr_d;
  logic [C_ID_W-1:0]    cand;
  logic [C_ID_W-1:0]    gnt_id;
  logic                 gnt_vld;
  logic [P_NUM_REQ-1:0] gnt;
  logic                 issue_ok;
  logic                 xfer;

  // issue register
  logic                   add_vld_q;
  logic                   add_vld_d;
  logic [P_DATA_SIZE-1:0] add_a_q;
  logic [P_DATA_SIZE-1:0] add_a_d;
  logic [P_DATA_SIZE-1:0] add_b_q;
  logic [P_DATA_SIZE-1:0] add_b_d;
  logic                   add_c_q;
  logic                   add_c_d;
  logic [C_ID_W-1:0]      add_id_q;
  logic [C_ID_W-1:0]      add_id_d;

  // ID tracking
  logic [P_LATENCY-1:0] trk_vld_q;
  logic [P_LATENCY-1:0] trk_vld_d;
  logic [P_LATENCY-1:0][C_ID_W-1:0] trk_id_q;
  logic [P_LATENCY-1:0][C_ID_W-1:0] trk_id_d;
  logic                 trk_vld;
  logic [C_ID_W-1:0]    trk_id;

  // error and post-reset suppression
  logic [C_SUP_W-1:0] sup_q;
  logic [C_SUP_W-1:0] sup_d;
  logic               err_q;
  logic               err_d;

  // credits
  logic [C_CNT_W-1:0] cnt_q;
  logic [C_CNT_W-1:0] cnt_d;
  logic               busy_q;
  logic               busy_d;

  // result FIFO
  logic [C_ENT_W-1:0] mem_q [P_FIFO_DEPTH];
  logic [C_PW1-1:0]   wr_q;
  logic [C_PW1-1:0]   wr_d;
  logic [C_PW1-1:0]   rd_q;
  logic [C_PW1-1:0]   rd_d;
  logic [C_PTR_W-1:0] wr_idx;
  logic [C_PTR_W-1:0] rd_idx;
  logic               empty;
  logic               push;
  logic               pop;

  function automatic logic [C_ID_W-1:0] wrap_add(
    input logic [C_ID_W-1:0] p,
    input int                i
  );
    int s;
    s = int'(p) + i;
    if (s >= P_NUM_REQ) begin
      s = s - P_NUM_REQ;
    end
    return C_ID_W'(s);
  endfunction

  // Reset gates the grant so no handshake completes while held in reset.
  assign issue_ok = !i_rst && (cnt_q < C_CNT_MAX);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    gnt     = '0;
    for (int i = 0; i < P_NUM_REQ; i++) begin
      cand = wrap_add(ptr_q, i);
      if (!gnt_vld && issue_ok && i_req_vld[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
    if (gnt_vld) begin
      gnt[gnt_id] = 1'b1;
    end
  end

  assign o_req_rdy = gnt;
  assign xfer      = gnt_vld;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = wrap_add(gnt_id, 1);
    end
  end

  always_comb begin
    add_vld_d = xfer;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    add_c_d   = add_c_q;
    add_id_d  = add_id_q;
    if (xfer) begin
      add_a_d  = i_req_a[gnt_id*P_DATA_SIZE +: P_DATA_SIZE];
      add_b_d  = i_req_b[gnt_id*P_DATA_SIZE +: P_DATA_SIZE];
      add_c_d  = i_req_c[gnt_id];
      add_id_d = gnt_id;
    end
  end

  assign o_add_vld = add_vld_q;
  assign o_add_a   = add_a_q;
  assign o_add_b   = add_b_q;
  assign o_add_c   = add_c_q;

  // Tracker runs in lockstep with the adder pipe.
  always_comb begin
    trk_vld_d    = trk_vld_q;
    trk_id_d     = trk_id_q;
    trk_vld_d[0] = add_vld_q;
    trk_id_d[0]  = add_id_q;
    for (int i = 1; i < P_LATENCY; i++) begin
      trk_vld_d[i] = trk_vld_q[i-1];
      trk_id_d[i]  = trk_id_q[i-1];
    end
  end

  assign trk_vld = trk_vld_q[P_LATENCY-1];
  assign trk_id  = trk_id_q[P_LATENCY-1];

  // The adder is not reset, so its pipe may hold stale valids.
  always_comb begin
    sup_d = sup_q;
    if (sup_q != '0) begin
      sup_d = sup_q - C_SUP_W'(1);
    end
  end

  always_comb begin
    err_d = err_q;
    if ((sup_q == '0) && (i_add_vld != trk_vld)) begin
      err_d = 1'b1;
    end
  end

  assign push   = i_add_vld & trk_vld;
  assign empty  = (wr_q == rd_q);
  assign pop    = !empty & i_res_rdy;
  assign wr_idx = wr_q[C_PTR_W-1:0];
  assign rd_idx = rd_q[C_PTR_W-1:0];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push) begin
      wr_d = wr_q + C_PW1'(1);
    end
    if (pop) begin
      rd_d = rd_q + C_PW1'(1);
    end
  end

  always_comb begin
    unique case ({xfer, pop})
      2'b10:   cnt_d = cnt_q + C_CNT_W'(1);
      2'b01:   cnt_d = cnt_q - C_CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    busy_d = (cnt_d != '0);
  end

  assign o_res_vld = !empty;
  assign {o_res_id, o_res_s} = mem_q[rd_idx];
  assign o_busy    = busy_q;
  assign o_err     = err_q;

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_idx] <= {trk_id, i_add_s};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q     <= '0;
      add_vld_q <= 1'b0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_c_q   <= 1'b0;
      add_id_q  <= '0;
      trk_vld_q <= '0;
      trk_id_q  <= '0;
      sup_q     <= C_SUP_INIT;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
    end else begin
      ptr_q     <= ptr_d;
      add_vld_q <= add_vld_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_c_q   <= add_c_d;
      add_id_q  <= add_id_d;
      trk_vld_q <= trk_vld_d;
      trk_id_q  <= trk_id_d;
      sup_q     <= sup_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
    end
  end

endmodule
